agu_sequencer: RTL and testbench

//  Sequences the address generation unit for one transfer descriptor at a time.

---
 rtl/agu_sequencer_if.sv | 43 ++++
 rtl/agu_sequencer.sv | 137 +++++++++++++
 tb/tb_agu_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/agu_sequencer_if.sv
// Descriptor handshake and AGU strobe bundle for agu_sequencer.
//  master : command-decoder side; drives the descriptor, beat_stall and abort
//  slave  : sequencer side; returns tr_ready, latched descriptor, AGU strobes,
//           busy and done
interface agu_sequencer_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic             tr_valid;
  logic             tr_ready;
  logic [39:0]      tr_addresses;
  logic [3:0]       tr_control;
  logic [LEN_W-1:0] tr_length;
  logic             beat_stall;
  logic             abort;
  logic [39:0]      latch_tr_addresses;
  logic [3:0]       latch_tr_control;
  logic             clear_agu;
  logic             byte_gen_ldinit;
  logic             rc_gen_ldinit;
  logic             mem_gen_ldinit;
  logic             byte_gen_enable;
  logic             mem_gen_enable;
  logic             rc_gen_enable;
  logic             fb_gen_enable;
  logic             busy;
  logic             done;

  modport master (
    output tr_valid, tr_addresses, tr_control, tr_length, beat_stall, abort,
    input  tr_ready, latch_tr_addresses, latch_tr_control, clear_agu,
    input  byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
    input  byte_gen_enable, mem_gen_enable, rc_gen_enable, fb_gen_enable,
    input  busy, done
  );

  modport slave (
    input  tr_valid, tr_addresses, tr_control, tr_length, beat_stall, abort,
    output tr_ready, latch_tr_addresses, latch_tr_control, clear_agu,
    output byte_gen_ldinit, rc_gen_ldinit, mem_gen_ldinit,
    output byte_gen_enable, mem_gen_enable, rc_gen_enable, fb_gen_enable,
    output busy, done
  );
endinterface

// File: rtl/agu_sequencer.sv
// AGU sequencer: accepts one transfer descriptor at a time, latches it, and
// steps the AGU through clear / load / per-beat increment phases so that at
// most one AGU strobe is high in any cycle.
//  sys_clk, sys_rst_n : clock, asynchronous active-low reset
//  bus (slave)        : descriptor handshake in, latched descriptor, AGU
//                       strobes, busy and done out
module agu_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  agu_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    StIdle, StClear, StLdByte, StLdRc, StLdMem,
    StBByte, StBMem, StBRc, StBFb, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [39:0]      addr_q, addr_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             clear_q, clear_d;
  logic [2:0]       ld_q, ld_d;    // {mem, rc, byte}
  logic [3:0]       en_q, en_d;    // {fb, rc, mem, byte}
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic in_idle, accept, stall, beat_end, abort_hit;

  assign in_idle   = (state_q == StIdle);
  assign accept    = in_idle && sys_rst_n && bus.tr_valid;
  assign stall     = bus.beat_stall;
  assign abort_hit = bus.abort && !in_idle;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    addr_d   = addr_q;
    ctl_d    = ctl_q;
    beat_end = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = bus.tr_addresses;
          ctl_d   = bus.tr_control;
          count_d = bus.tr_length;
          state_d = bus.tr_control[3] ? StClear : StLdByte;
        end
      end
      StClear:  state_d = StLdByte;
      StLdByte: state_d = StLdRc;
      StLdRc:   state_d = StLdMem;
      StLdMem:  state_d = (count_q == '0) ? StDone : StBByte;
      StBByte: begin
        if (!stall) state_d = StBMem;
      end
      StBMem: begin
        if (!stall) begin
          if (ctl_q[0])      state_d = StBRc;
          else if (ctl_q[2]) state_d = StBFb;
          else               beat_end = 1'b1;
        end
      end
      StBRc: begin
        if (!stall) begin
          if (ctl_q[2]) state_d = StBFb;
          else          beat_end = 1'b1;
        end
      end
      StBFb: begin
        if (!stall) beat_end = 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Last active sub-phase of a beat retires it; count never goes below zero.
    if (beat_end) begin
      if (count_q != '0) count_d = count_q - 1'b1;
      state_d = (count_q <= 1) ? StDone : StBByte;
    end

    if (abort_hit) state_d = StIdle;

    // Strobes are registered against the state being entered, so each one is
    // high exactly in the cycle its state is current. Abort re-clears the AGU.
    clear_d = (state_d == StClear) || abort_hit;
    ld_d    = {state_d == StLdMem, state_d == StLdRc, state_d == StLdByte};
    en_d    = {state_d == StBFb, state_d == StBRc, state_d == StBMem, state_d == StBByte};
    done_d  = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      ctl_q   <= '0;
      clear_q <= 1'b0;
      ld_q    <= '0;
      en_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      ctl_q   <= ctl_d;
      clear_q <= clear_d;
      ld_q    <= ld_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tr_ready           = sys_rst_n && in_idle;
  assign bus.latch_tr_addresses = addr_q;
  assign bus.latch_tr_control   = ctl_q;
  assign bus.clear_agu          = clear_q;
  assign bus.byte_gen_ldinit    = ld_q[0];
  assign bus.rc_gen_ldinit      = ld_q[1];
  assign bus.mem_gen_ldinit     = ld_q[2];
  // A stall must suppress the increment in the very cycle it is seen, since the
  // state is held and the same sub-phase re-issues once the stall drops.
  assign bus.byte_gen_enable    = en_q[0] && !stall;
  assign bus.mem_gen_enable     = en_q[1] && !stall;
  assign bus.rc_gen_enable      = en_q[2] && !stall;
  assign bus.fb_gen_enable      = en_q[3] && !stall;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;

endmodule

// File: tb/tb_agu_sequencer.sv
module tb_agu_sequencer;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  agu_sequencer_if #(.LEN_W(8)) bus ();

  agu_sequencer #(.LEN_W(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // {clear, ldb, ldr, ldm, byte_en, mem_en, rc_en, fb_en}
  logic [7:0] stb;
  assign stb = {bus.clear_agu, bus.byte_gen_ldinit, bus.rc_gen_ldinit, bus.mem_gen_ldinit,
                bus.byte_gen_enable, bus.mem_gen_enable, bus.rc_gen_enable, bus.fb_gen_enable};

  typedef struct {
    logic [39:0] addr;
    logic [3:0]  ctl;
    logic [7:0]  len;
    int          stall_at;   // first cycle after handshake with beat_stall high
    int          stall_n;    // 0 = no stall
    int          abort_at;   // 0 = no abort
    bit          rnd;        // random stalls instead of stall_at/stall_n
    int          e_lat;      // cycle of done after handshake; 0 = none, -1 = unchecked
    int          e_done;
    int          e_clr, e_ldb, e_ldr, e_ldm, e_b, e_m, e_r, e_f;
  } vec_t;

  vec_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w, c, lat, dcnt;
    int cnt[8];
    vec_t e;
    bit timeout;
    w = 0;
    while (!bus.tr_ready && w < 50) begin
      @(negedge sys_clk); #1; w++;
    end
    check("accept_wait", w, 0);
    bus.tr_valid     = 1'b1;
    bus.tr_addresses = v.addr;
    bus.tr_control   = v.ctl;
    bus.tr_length    = v.len;
    sb.push_back(v);
    @(posedge sys_clk);
    @(negedge sys_clk);
    // tr_* must be ignored while busy
    bus.tr_valid     = 1'b0;
    bus.tr_addresses = {8'($urandom), 32'($urandom)};
    bus.tr_control   = 4'($urandom);
    bus.tr_length    = 8'($urandom);
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    lat = 0; dcnt = 0; timeout = 1'b0;
    c = 1;
    forever begin
      bus.beat_stall = v.rnd ? ($urandom_range(0, 3) == 0)
                             : (c >= v.stall_at && c < v.stall_at + v.stall_n);
      bus.abort      = (v.abort_at != 0) && (c == v.abort_at);
      #1;
      check("strobe_onehot", ($countones(stb) <= 1), 1);
      check("ready_is_not_busy", bus.tr_ready, !bus.busy);
      for (int i = 0; i < 8; i++) if (stb[7-i]) cnt[i]++;
      if (bus.done) begin dcnt++; lat = c; end
      if (!bus.busy) break;
      if (c > 3000) begin timeout = 1'b1; break; end
      @(negedge sys_clk);
      c++;
    end
    bus.beat_stall = 1'b0;
    bus.abort      = 1'b0;
    check("transfer_timeout", timeout, 0);
    e = sb.pop_front();
    if (e.e_lat >= 0) check("done_latency", lat, e.e_lat);
    check("done_pulses", dcnt, e.e_done);
    check("clear_agu_cnt", cnt[0], e.e_clr);
    check("byte_ldinit_cnt", cnt[1], e.e_ldb);
    check("rc_ldinit_cnt", cnt[2], e.e_ldr);
    check("mem_ldinit_cnt", cnt[3], e.e_ldm);
    check("byte_enable_cnt", cnt[4], e.e_b);
    check("mem_enable_cnt", cnt[5], e.e_m);
    check("rc_enable_cnt", cnt[6], e.e_r);
    check("fb_enable_cnt", cnt[7], e.e_f);
    check("latch_addr", bus.latch_tr_addresses, e.addr);
    check("latch_ctl", bus.latch_tr_control, e.ctl);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    // addr, ctl, len, stall_at, stall_n, abort_at, rnd,
    // lat, done, clr, ldb, ldr, ldm, b, m, r, f
    tbl[0]  = '{40'h123456789A, 4'b1000, 8'd0,   0, 0, 0, 1'b0, 5,    1, 1, 1, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{40'hA5A5_0000_11, 4'b0101, 8'd3, 0, 0, 0, 1'b0, 16,   1, 0, 1, 1, 1, 3, 3, 3, 3};
    tbl[2]  = '{40'h0000_FFFF_22, 4'b0000, 8'd2, 5, 5, 0, 1'b0, 13,   1, 0, 1, 1, 1, 2, 2, 0, 0};
    tbl[3]  = '{40'h1111_2222_33, 4'b0001, 8'd1, 0, 0, 0, 1'b0, 7,    1, 0, 1, 1, 1, 1, 1, 1, 0};
    tbl[4]  = '{40'h4444_5555_44, 4'b0100, 8'd4, 0, 0, 0, 1'b0, 16,   1, 0, 1, 1, 1, 4, 4, 0, 4};
    tbl[5]  = '{40'hFFFF_FFFF_FF, 4'b1111, 8'd2, 0, 0, 0, 1'b0, 13,   1, 1, 1, 1, 1, 2, 2, 2, 2};
    tbl[6]  = '{40'h0BAD_CAFE_66, 4'b0000, 8'd200, 0, 0, 8, 1'b0, 0,  0, 1, 1, 1, 1, 3, 2, 0, 0};
    tbl[7]  = '{40'h7777_8888_77, 4'b0000, 8'd1, 1, 3, 0, 1'b0, 6,    1, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{40'h0102_0304_05, 4'b0101, 8'd255, 0, 0, 0, 1'b0, 1024, 1, 0, 1, 1, 1, 255, 255, 255, 255};
    tbl[9]  = '{40'h9999_AAAA_99, 4'b0000, 8'd3, 5, 4, 7, 1'b0, 0,    0, 1, 1, 1, 1, 1, 0, 0, 0};
    tbl[10] = '{40'hDEAD_BEEF_10, 4'b1000, 8'd2, 0, 0, 2, 1'b0, 0,    0, 2, 1, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{40'h3C3C_C3C3_11, 4'b0110, 8'd2, 6, 3, 0, 1'b0, 13,   1, 0, 1, 1, 1, 2, 2, 0, 2};

    bus.tr_valid = 1'b0; bus.tr_addresses = '0; bus.tr_control = '0; bus.tr_length = '0;
    bus.beat_stall = 1'b0; bus.abort = 1'b0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    check("rst_tr_ready", bus.tr_ready, 0);
    check("rst_strobes", stb, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_latch_addr", bus.latch_tr_addresses, 0);
    check("rst_latch_ctl", bus.latch_tr_control, 0);
    sys_rst_n = 1'b1;
    #1;
    check("post_rst_tr_ready", bus.tr_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Abort while idle has no effect
    bus.abort = 1'b1;
    @(negedge sys_clk);
    bus.abort = 1'b0;
    #1;
    check("idle_abort_clear", bus.clear_agu, 0);
    check("idle_abort_busy", bus.busy, 0);

    // Asynchronous reset in the middle of a beat
    bus.tr_valid = 1'b1; bus.tr_addresses = 40'h55_6677_8899; bus.tr_control = 4'b0101;
    bus.tr_length = 8'd5;
    @(posedge sys_clk);
    @(negedge sys_clk);
    bus.tr_valid = 1'b0;
    repeat (5) @(negedge sys_clk);
    #1;
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_enable", bus.byte_gen_enable | bus.mem_gen_enable | bus.rc_gen_enable
                            | bus.fb_gen_enable, 1);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_strobes", stb, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_tr_ready", bus.tr_ready, 0);
    check("midrst_latch_addr", bus.latch_tr_addresses, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("midrst_release_ready", bus.tr_ready, 1);

    // Random descriptors with random stalls
    for (int k = 0; k < 25; k++) begin
      rv.addr = {8'($urandom), 32'($urandom)};
      rv.ctl  = 4'($urandom);
      rv.len  = 8'($urandom_range(0, 12));
      rv.stall_at = 0; rv.stall_n = 0; rv.abort_at = 0; rv.rnd = 1'b1;
      rv.e_lat = -1; rv.e_done = 1;
      rv.e_clr = rv.ctl[3] ? 1 : 0;
      rv.e_ldb = 1; rv.e_ldr = 1; rv.e_ldm = 1;
      rv.e_b = int'(rv.len); rv.e_m = int'(rv.len);
      rv.e_r = rv.ctl[0] ? int'(rv.len) : 0;
      rv.e_f = rv.ctl[2] ? int'(rv.len) : 0;
      run_vec(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
